dnn_mac_sequencer: RTL

//  Sequencer for the time-multiplexed 4-4-2 DNN datapath: one shared MAC serves every neuron.

---
 rtl/dnn_pkg.sv | 37 +++
 rtl/dnn_wb_pipe.sv | 39 +++
 rtl/dnn_mac_sequencer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/dnn_pkg.sv
// Shared types and sizing for the time-multiplexed 4-4-2 DNN sequencer.
// Optional feature macro: DNN_SEQ_PERF_EN (performance counters on the top level).
package dnn_pkg;

  localparam int unsigned N_IN  = 4;
  localparam int unsigned N_HID = 4;
  localparam int unsigned N_OUT = 2;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Index width that never collapses to zero bits
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned NEU_W = idx_w(max2(N_HID, N_OUT));
  localparam int unsigned SRC_W = idx_w(max2(N_IN, N_HID));
  localparam int unsigned HID_W = idx_w(N_HID);
  localparam int unsigned OUT_W = idx_w(N_OUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_L1,
    S_DRAIN1,
    S_L2,
    S_DRAIN2
  } seq_state_t;

  // Writeback tag: layer 0 targets a hidden register, layer 1 an output register
  typedef struct packed {
    logic             layer;
    logic [NEU_W-1:0] neuron;
  } wb_tag_t;

endpackage

// File: rtl/dnn_wb_pipe.sv
// Writeback tag delay line: a tag pushed with the last-source MAC issue of a neuron
// emerges exactly DEPTH cycles later, aligned with the accumulator result.
module dnn_wb_pipe
  import dnn_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic    clk,
  input  logic    clr,
  input  logic    in_valid,
  input  wb_tag_t in_tag,
  output logic    out_valid,
  output wb_tag_t out_tag
);

  logic [DEPTH-1:0] r_vld;
  wb_tag_t          r_tag [DEPTH];

  // Shift valid/tag one stage per cycle; clear drops every in-flight tag
  always_ff @(posedge clk) begin
    if (clr) begin
      r_vld <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_tag[i] <= '0;
      end
    end else begin
      r_vld[0] <= in_valid;
      r_tag[0] <= in_tag;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_tag[i] <= r_tag[i-1];
      end
    end
  end

  assign out_valid = r_vld[DEPTH-1];
  assign out_tag   = r_tag[DEPTH-1];

endmodule

// File: rtl/dnn_mac_sequencer.sv
// Control sequencer for the shared-MAC 4-4-2 DNN: accepts a sample, issues the
// layer-1 and layer-2 MAC streams, strobes hidden/output writebacks and holds
// the out0/out1 ready levels. Optional macro DNN_SEQ_PERF_EN adds perf_cycles
// and perf_drops counters.
module dnn_mac_sequencer
  import dnn_pkg::*;
#(
  parameter int unsigned MAC_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_ready,
  output logic             x_load,
  output logic             busy,
  output logic             mac_en,
  output logic             mac_clr,
  output logic             mac_layer,
  output logic [NEU_W-1:0] mac_neuron,
  output logic [SRC_W-1:0] mac_src,
  output logic             hid_we,
  output logic [HID_W-1:0] hid_idx,
  output logic             out_we,
  output logic [OUT_W-1:0] out_idx,
  output logic             out0_ready,
  output logic             out1_ready
`ifdef DNN_SEQ_PERF_EN
  ,
  output logic [15:0]      perf_cycles,
  output logic [15:0]      perf_drops
`endif
);

  localparam int unsigned DRN_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  seq_state_t       r_state, w_state_nxt;
  logic [SRC_W-1:0] r_src, w_src_nxt;
  logic [NEU_W-1:0] r_neu, w_neu_nxt;
  logic [DRN_W-1:0] r_drn, w_drn_nxt;
  logic             r_out0_rdy, r_out1_rdy;
  logic             w_accept;
  logic             w_push;
  wb_tag_t          w_push_tag;
  logic             w_wb_vld;
  wb_tag_t          w_wb_tag;

  // State and loop counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_src   <= '0;
      r_neu   <= '0;
      r_drn   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_src   <= w_src_nxt;
      r_neu   <= w_neu_nxt;
      r_drn   <= w_drn_nxt;
    end
  end

  // Next state, counter advance and MAC issue controls
  always_comb begin
    w_state_nxt       = r_state;
    w_src_nxt         = r_src;
    w_neu_nxt         = r_neu;
    w_drn_nxt         = r_drn;
    w_accept          = 1'b0;
    w_push            = 1'b0;
    w_push_tag        = '0;
    x_load            = 1'b0;
    busy              = 1'b1;
    mac_en            = 1'b0;
    mac_clr           = 1'b0;
    mac_layer         = 1'b0;
    mac_neuron        = '0;
    mac_src           = '0;
    case (r_state)
      S_IDLE: begin
        busy     = 1'b0;
        x_load   = in_ready;
        w_accept = in_ready;
        if (in_ready) w_state_nxt = S_L1;
      end
      S_L1: begin
        mac_en     = 1'b1;
        mac_layer  = 1'b0;
        mac_neuron = r_neu;
        mac_src    = r_src;
        mac_clr    = (r_src == '0);
        if (r_src == SRC_W'(N_IN - 1)) begin
          w_push            = 1'b1;
          w_push_tag.layer  = 1'b0;
          w_push_tag.neuron = r_neu;
          w_src_nxt         = '0;
          if (r_neu == NEU_W'(N_HID - 1)) begin
            w_neu_nxt   = '0;
            w_state_nxt = S_DRAIN1;
          end else begin
            w_neu_nxt = r_neu + 1'b1;
          end
        end else begin
          w_src_nxt = r_src + 1'b1;
        end
      end
      S_DRAIN1: begin
        if (r_drn == DRN_W'(MAC_LAT - 1)) begin
          w_drn_nxt   = '0;
          w_state_nxt = S_L2;
        end else begin
          w_drn_nxt = r_drn + 1'b1;
        end
      end
      S_L2: begin
        mac_en     = 1'b1;
        mac_layer  = 1'b1;
        mac_neuron = r_neu;
        mac_src    = r_src;
        mac_clr    = (r_src == '0);
        if (r_src == SRC_W'(N_HID - 1)) begin
          w_push            = 1'b1;
          w_push_tag.layer  = 1'b1;
          w_push_tag.neuron = r_neu;
          w_src_nxt         = '0;
          if (r_neu == NEU_W'(N_OUT - 1)) begin
            w_neu_nxt   = '0;
            w_state_nxt = S_DRAIN2;
          end else begin
            w_neu_nxt = r_neu + 1'b1;
          end
        end else begin
          w_src_nxt = r_src + 1'b1;
        end
      end
      S_DRAIN2: begin
        if (r_drn == DRN_W'(MAC_LAT - 1)) begin
          w_drn_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_drn_nxt = r_drn + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  dnn_wb_pipe #(
    .DEPTH (MAC_LAT)
  ) u_wb_pipe (
    .clk       (clk),
    .clr       (rst),
    .in_valid  (w_push),
    .in_tag    (w_push_tag),
    .out_valid (w_wb_vld),
    .out_tag   (w_wb_tag)
  );

  // Decode the emerging tag into hidden/output write strobes; indices idle at 0
  always_comb begin
    hid_we  = w_wb_vld && !w_wb_tag.layer;
    out_we  = w_wb_vld &&  w_wb_tag.layer;
    hid_idx = hid_we ? w_wb_tag.neuron[HID_W-1:0] : '0;
    out_idx = out_we ? w_wb_tag.neuron[OUT_W-1:0] : '0;
  end

  // Ready levels: set after the output write, cleared at the end of the next accept
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out0_rdy <= 1'b0;
      r_out1_rdy <= 1'b0;
    end else begin
      if (w_accept) begin
        r_out0_rdy <= 1'b0;
        r_out1_rdy <= 1'b0;
      end
      if (out_we && out_idx == OUT_W'(0)) r_out0_rdy <= 1'b1;
      if (out_we && out_idx == OUT_W'(1)) r_out1_rdy <= 1'b1;
    end
  end

  assign out0_ready = r_out0_rdy;
  assign out1_ready = r_out1_rdy;

`ifdef DNN_SEQ_PERF_EN
  logic [15:0] r_perf_run, r_perf_cycles, r_perf_drops;

  // Cycle count from accept to the final output write, plus saturating drop count
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_run    <= '0;
      r_perf_cycles <= '0;
      r_perf_drops  <= '0;
    end else begin
      if (w_accept) begin
        r_perf_run <= 16'd1;
      end else if (r_state != S_IDLE && r_perf_run != '1) begin
        r_perf_run <= r_perf_run + 1'b1;
      end
      if (out_we && out_idx == OUT_W'(N_OUT - 1)) begin
        r_perf_cycles <= r_perf_run + 1'b1;
      end
      if (in_ready && r_state != S_IDLE && r_perf_drops != '1) begin
        r_perf_drops <= r_perf_drops + 1'b1;
      end
    end
  end

  assign perf_cycles = r_perf_cycles;
  assign perf_drops  = r_perf_drops;
`endif

endmodule
